// File: rtl/mix_columns_sequencer.sv
// mix_columns_sequencer: AES MixColumns on a 128-bit state, one column per cycle through registered xtime lanes; INV_MIX_COLUMNS_EN adds InvMixColumns selected by Inverse
module mix_columns_sequencer (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         InValid,
  output logic         InReady,
  input  logic [127:0] InState,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [127:0] OutState
`ifdef INV_MIX_COLUMNS_EN
  ,
  input  logic         Inverse
`endif
);
`ifdef INV_MIX_COLUMNS_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction
  state_t state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [127:0] work_q, work_d;
  logic out_valid_q, out_valid_d;
  logic [LAT-1:0] wv_q, wv_d;
  logic [1:0] wc_q [LAT];
  logic [1:0] wc_d [LAT];
  logic [7:0] a_q [LAT][4];
  logic [7:0] a_d [LAT][4];
  logic [7:0] x2_q [4];
  logic [7:0] x2_d [4];
  logic [7:0] iss [4];
  logic [7:0] res [4];
  logic [31:0] cw [4];
  logic wr;
  logic [1:0] wcol;
`ifdef INV_MIX_COLUMNS_EN
  logic mode_q, mode_d;
  logic [7:0] x2b_q [4];
  logic [7:0] x2b_d [4];
  logic [7:0] x2c_q [4];
  logic [7:0] x2c_d [4];
  logic [7:0] x4_q [4];
  logic [7:0] x4_d [4];
  logic [7:0] x4b_q [4];
  logic [7:0] x4b_d [4];
  logic [7:0] x8_q [4];
  logic [7:0] x8_d [4];
`endif
  assign InReady  = state_q == IDLE;
  assign OutValid = out_valid_q;
  assign OutState = work_q;
  always_comb begin
    for (int c = 0; c < 4; c++) cw[c] = work_q[127-32*c -: 32];
    for (int i = 0; i < 4; i++) begin
      iss[i]  = cw[col_q][31-8*i -: 8];
      x2_d[i] = xt(iss[i]);
      res[i]  = x2_q[i] ^ x2_q[(i+1)%4] ^ a_q[0][(i+1)%4] ^ a_q[0][(i+2)%4] ^ a_q[0][(i+3)%4];
    end
    a_d[0]  = iss;
    wv_d[0] = state_q == ISSUE;
    wc_d[0] = col_q;
    wr      = wv_q[0];
    wcol    = wc_q[0];
`ifdef INV_MIX_COLUMNS_EN
    mode_d = mode_q;
    x2b_d  = x2_q;
    x2c_d  = x2b_q;
    x4b_d  = x4_q;
    for (int i = 0; i < 4; i++) begin
      x4_d[i] = xt(x2_q[i]);
      x8_d[i] = xt(x4_q[i]);
    end
    for (int s = 1; s < LAT; s++) begin
      wv_d[s] = wv_q[s-1];
      wc_d[s] = wc_q[s-1];
      a_d[s]  = a_q[s-1];
    end
    if (mode_q) begin
      wr   = wv_q[LAT-1];
      wcol = wc_q[LAT-1];
      for (int i = 0; i < 4; i++)
        res[i] = (x8_q[i] ^ x4b_q[i] ^ x2c_q[i])
               ^ (x8_q[(i+1)%4] ^ x2c_q[(i+1)%4] ^ a_q[2][(i+1)%4])
               ^ (x8_q[(i+2)%4] ^ x4b_q[(i+2)%4] ^ a_q[2][(i+2)%4])
               ^ (x8_q[(i+3)%4] ^ a_q[2][(i+3)%4]);
    end
`endif
    work_d = work_q;
    for (int c = 0; c < 4; c++)
      if (wr && wcol == 2'(c)) work_d[127-32*c -: 32] = {res[0], res[1], res[2], res[3]};
    state_d     = state_q;
    col_d       = col_q;
    out_valid_d = out_valid_q;
    if (state_q == IDLE && InValid) begin
      work_d  = InState;
      col_d   = 2'd0;
      state_d = ISSUE;
`ifdef INV_MIX_COLUMNS_EN
      mode_d  = Inverse;
`endif
    end else if (state_q == ISSUE) begin
      col_d   = col_q + 2'd1;
      state_d = col_q == 2'd3 ? DRAIN : ISSUE;
    end else if (state_q == DRAIN && wr && wcol == 2'd3) begin
      state_d     = DONE;
      out_valid_d = 1'b1;
    end else if (state_q == DONE && OutReady) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      wv_q        <= '0;
`ifdef INV_MIX_COLUMNS_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      work_q      <= work_d;
      out_valid_q <= out_valid_d;
      wv_q        <= wv_d;
`ifdef INV_MIX_COLUMNS_EN
      mode_q      <= mode_d;
`endif
    end
  end
  always_ff @(posedge Clk) begin
    wc_q  <= wc_d;
    a_q   <= a_d;
    x2_q  <= x2_d;
`ifdef INV_MIX_COLUMNS_EN
    x2b_q <= x2b_d;
    x2c_q <= x2c_d;
    x4_q  <= x4_d;
    x4b_q <= x4b_d;
    x8_q  <= x8_d;
`endif
  end
endmodule

// File: doc/mix_columns_sequencer.md
# mix_columns_sequencer

- Sequences one AES MixColumns round transform over a 128-bit state.
- Uses four registered GF(2^8) multiply-by-2 lanes, one lane per row byte, with the same behaviour as the GFMulBy2 primitive: 1-cycle registered xtime.
- Processes one column per cycle and pipelines the lanes so a new column issues every cycle.
- Sits between ShiftRows and AddRoundKey in the round datapath, with valid/ready handshakes on both sides.

## Interface
Parameters:
- None. Widths are fixed by AES: 128-bit state, 8-bit bytes.

Ports:
- Clk  input  1  — single clock; all state updates on its rising edge.
- Rst  input  1  — reset, synchronous and active-high.
- InValid  input  1  — InState holds a valid state.
- InReady  output  1  — block can accept a state; high only in IDLE.
- InState  input  128  — input state. Byte k = bits [127-8k -: 8]. Column c = bytes 4c..4c+3, row 0 first.
- OutValid  output  1  — OutState holds a finished state.
- OutReady  input  1  — downstream accepts OutState.
- OutState  output  128  — MixColumns result, same byte order as InState.
- Inverse  input  1  — present only with INV_MIX_COLUMNS_EN. Sampled on the accept edge.

## Operation
States:
- IDLE: InReady=1. On InValid&&InReady, latch InState and the mode, clear ColIdx, go to ISSUE.
- ISSUE: each cycle, drive column ColIdx into the four xtime lanes, then increment ColIdx (2 bits). After ColIdx=3 issues, go to DRAIN.
- DRAIN: wait for the last column write-back.
- DONE: OutValid=1. On OutReady, go to IDLE.

Column arithmetic (forward):
- Each output byte is r'_i = 2·a_i ⊕ 3·a_{i+1} ⊕ a_{i+2} ⊕ a_{i+3}, with indices mod 4.
- 3·x is computed as xtime(x) ⊕ x.
- The plain a terms come from a 1-cycle delayed copy of the issued column, aligned with the lane outputs.
- The result column is written into the working register at column ColIdx-1, i.e. the delayed index.

Boundary rules:
- InValid while not in IDLE is ignored; InReady=0 there.
- OutState stays stable while OutValid=1 and OutReady=0.
- No input is accepted in the same cycle as the output handshake. InReady rises the cycle after DONE→IDLE.
- Rst in any state, including mid-column, forces IDLE on the next edge and discards in-flight data.
- Lane registers need no reset; their contents are don't-care outside ISSUE/DRAIN.

## Timing
- Reset values: state=IDLE, OutValid=0, OutState=128'h0, ColIdx=0.
- InReady=1 from the first edge after Rst deasserts.
- Latency, forward: accept at edge E. Columns 0..3 are written at edges E+2..E+5. OutValid=1 after edge E+5.
- Throughput: one state per 6 cycles plus any OutReady stall.
- OutState is driven directly from the working register; there is no combinational path from InState to OutState.

## Configuration
Macro: INV_MIX_COLUMNS_EN.

Without the macro:
- The block is forward-only and the Inverse port does not exist.

With the macro:
- The Inverse port exists.
- When Inverse=1 at accept, each column passes through three chained registered xtime levels to form 2x, 4x and 8x.
- The output is r'_i = 14·a_i ⊕ 11·a_{i+1} ⊕ 13·a_{i+2} ⊕ 9·a_{i+3}.
- The plain-term delay line is 3 deep.
- Columns are written at edges E+4..E+7; OutValid=1 after edge E+7.
- Inverse=0 keeps the forward 5-cycle latency.

## Test plan
- Forward vector: accept every column = db 13 53 45 → every output column = 8e 4d a1 bc. OutValid after exactly 5 edges; InReady=0 throughout.
- Mixed columns: input columns f2 0a 22 5c | 01 01 01 01 | c6 c6 c6 c6 | d4 d4 d4 d5 → output columns 9f dc 58 9d | 01 01 01 01 | c6 c6 c6 c6 | d5 d5 d7 d6. Checks column ordering and the xtime 0x1b reduction.
- Backpressure: hold OutReady=0 for 10 cycles with a new InValid pending → OutState stable, InReady=0, second state accepted only after the handshake plus 1 cycle.
- Reset mid-operation: assert Rst at edge E+3 → OutValid never rises for that state. Next state 2d 26 31 4c (all columns) returns 4d 7e bd f8.
- Back-to-back: 3 states with OutReady=1 → one output per 6 cycles, results in order.
- INV_MIX_COLUMNS_EN build, Inverse=1: columns 8e 4d a1 bc → db 13 53 45, OutValid after 7 edges. Then Inverse=0 on the next state returns to 5-cycle latency.
